// File: rtl/ex_muldiv_pkg.sv
// Shared constants for the EX-stage multiply/divide unit: RV32M funct3 codes,
// FSM state encodings and operand signedness decode.
package ex_muldiv_pkg;

  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  localparam logic [2:0] EXE_RES_MULDIV = 3'b111;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_SIGN = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  function automatic logic op_a_signed(input logic [2:0] op);
    return (op == MD_MUL) || (op == MD_MULH) || (op == MD_MULHSU) ||
           (op == MD_DIV) || (op == MD_REM);
  endfunction

  function automatic logic op_b_signed(input logic [2:0] op);
    return (op == MD_MUL) || (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
  endfunction

endpackage

// File: rtl/ex_muldiv_step.sv
// One radix-2 iteration: shift-add multiply step or restoring divide step on
// the {acc, lo} register pair. Chained UNROLL times by ex_muldiv.
module ex_muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic            div_mode,
  input  logic [XLEN-1:0] acc_i,
  input  logic [XLEN-1:0] lo_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] acc_o,
  output logic [XLEN-1:0] lo_o
);

  logic [XLEN:0] sum;
  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;
  logic          ge;

  always_comb begin
    sum     = {1'b0, acc_i} + (lo_i[0] ? {1'b0, b_i} : '0);
    shifted = {acc_i, lo_i[XLEN-1]};
    diff    = shifted - {1'b0, b_i};
    // Explicit compare: shifted can reach 2*divisor-1, so diff's MSB is not a borrow flag
    ge      = (shifted >= {1'b0, b_i});
    if (div_mode) begin
      acc_o = ge ? diff[XLEN-1:0] : shifted[XLEN-1:0];
      lo_o  = {lo_i[XLEN-2:0], ge};
    end else begin
      acc_o = sum[XLEN:1];
      lo_o  = {sum[0], lo_i[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit beside the EX ALU. Works on operand
// magnitudes, fixes signs in a final cycle, stalls the pipe until done.
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int UNROLL    = 1,
  parameter int REGADDR_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [2:0]           op,
  input  logic [XLEN-1:0]      opv1,
  input  logic [XLEN-1:0]      opv2,
  input  logic [REGADDR_W-1:0] reg_waddr_i,
  input  logic                 flush,
  output logic                 stallreq,
  output logic                 busy,
  output logic                 done,
  output logic [XLEN-1:0]      result,
  output logic [REGADDR_W-1:0] reg_waddr_o,
  output logic                 we_o
);

  localparam int N     = XLEN / UNROLL;
  localparam int CNT_W = $clog2(N + 1);
  localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2:0]           op_q, op_d;
  logic [REGADDR_W-1:0] waddr_q, waddr_d;
  logic [REGADDR_W-1:0] reg_waddr_q, reg_waddr_d;
  logic                 neg_a_q, neg_a_d, neg_b_q, neg_b_d;
  logic [XLEN-1:0]      acc_q, acc_d, lo_q, lo_d, b_q, b_d;
  logic [XLEN-1:0]      result_q, result_d;

  logic [UNROLL:0][XLEN-1:0] acc_c;
  logic [UNROLL:0][XLEN-1:0] lo_c;

  logic                 a_neg, b_neg, div_zero, div_ovf;
  logic [XLEN-1:0]      mag_a, mag_b, special_res, sign_res;
  logic signed [2*XLEN-1:0] prod_s;
  logic signed [XLEN-1:0]   quot_s, rem_s;

  always_comb begin
    a_neg    = op_a_signed(op) & opv1[XLEN-1];
    b_neg    = op_b_signed(op) & opv2[XLEN-1];
    mag_a    = a_neg ? -opv1 : opv1;
    mag_b    = b_neg ? -opv2 : opv2;
    div_zero = op[2] && (opv2 == '0);
    div_ovf  = ((op == MD_DIV) || (op == MD_REM)) && (opv1 == XMIN) && (&opv2);
    if (op[1]) special_res = div_zero ? opv1 : '0;
    else       special_res = div_zero ? '1 : XMIN;
  end

  assign acc_c[0] = acc_q;
  assign lo_c[0]  = lo_q;

  for (genvar i = 0; i < UNROLL; i++) begin : g_step
    ex_muldiv_step #(.XLEN(XLEN)) u_step (
      .div_mode (op_q[2]),
      .acc_i    (acc_c[i]),
      .lo_i     (lo_c[i]),
      .b_i      (b_q),
      .acc_o    (acc_c[i+1]),
      .lo_o     (lo_c[i+1])
    );
  end

  always_comb begin
    prod_s = signed'({acc_q, lo_q});
    if (neg_a_q ^ neg_b_q) prod_s = -prod_s;
    quot_s = signed'(lo_q);
    if (neg_a_q ^ neg_b_q) quot_s = -quot_s;
    rem_s = signed'(acc_q);
    if (neg_a_q) rem_s = -rem_s;
    if (!op_q[2]) sign_res = (op_q[1:0] == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
    else          sign_res = op_q[1] ? rem_s : quot_s;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    waddr_d     = waddr_q;
    neg_a_d     = neg_a_q;
    neg_b_d     = neg_b_q;
    acc_d       = acc_q;
    lo_d        = lo_q;
    b_d         = b_q;
    result_d    = result_q;
    reg_waddr_d = reg_waddr_q;
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (start) begin
          op_d    = op;
          waddr_d = reg_waddr_i;
          neg_a_d = a_neg;
          neg_b_d = b_neg;
          acc_d   = '0;
          // Divide shifts the dividend out of lo; multiply shifts the multiplier out
          lo_d    = op[2] ? mag_a : mag_b;
          b_d     = op[2] ? mag_b : mag_a;
          if (div_zero || div_ovf) begin
            state_d     = ST_DONE;
            result_d    = special_res;
            reg_waddr_d = reg_waddr_i;
          end else begin
            state_d = ST_CALC;
            cnt_d   = CNT_W'(N);
          end
        end
        ST_CALC: begin
          acc_d = acc_c[UNROLL];
          lo_d  = lo_c[UNROLL];
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = ST_SIGN;
        end
        ST_SIGN: begin
          result_d    = sign_res;
          reg_waddr_d = waddr_q;
          state_d     = ST_DONE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      result_q    <= '0;
      reg_waddr_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      reg_waddr_q <= reg_waddr_d;
    end
  end

  always_ff @(posedge clk) begin
    op_q    <= op_d;
    waddr_q <= waddr_d;
    neg_a_q <= neg_a_d;
    neg_b_q <= neg_b_d;
    acc_q   <= acc_d;
    lo_q    <= lo_d;
    b_q     <= b_d;
  end

  assign stallreq    = !rst && !flush &&
                       (((state_q == ST_IDLE) && start) || (state_q == ST_CALC) || (state_q == ST_SIGN));
  assign done        = !rst && !flush && (state_q == ST_DONE);
  assign we_o        = done;
  assign busy        = (state_q != ST_IDLE);
  assign result      = result_q;
  assign reg_waddr_o = reg_waddr_q;

endmodule
